// File: rtl/sqrt_sum_pipe.sv
// Sum of integer square roots of N_ARGS unsigned W-bit operands; build macro SQRT_SUM_PIPE_GATE_EN.
// Latency LAT = W/2 + $clog2(N_ARGS) cycles from arg_vld to res_vld, one operand set per cycle.
// No backpressure: every accepted set leaves exactly LAT cycles later, in order.
module sqrt_sum_pipe #(
  parameter int N_ARGS = 3,
  parameter int W      = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                arg_vld,
  input  logic [N_ARGS*W-1:0]                 arg,
  output logic                                res_vld,
  output logic [W/2+$clog2(N_ARGS)-1:0]       res
);

  localparam int HW    = W / 2;
  localparam int LOGN  = $clog2(N_ARGS);
  localparam int OUT_W = HW + LOGN;
  localparam int LAT   = HW + LOGN;
  localparam int RW    = HW + 2;

  // Number of live elements entering adder level l.
  function automatic int lvl_cnt(input int l);
    int c = N_ARGS;
    for (int n = 0; n < l; n++) c = (c + 1) / 2;
    return c;
  endfunction

  // One restoring digit-recurrence step: brings in two radicand bits and
  // resolves the next root bit.
  function automatic void sqrt_step(
    input  logic [RW-1:0] rem_i,
    input  logic [HW-1:0] root_i,
    input  logic [1:0]    bits_i,
    output logic [RW-1:0] rem_o,
    output logic [HW-1:0] root_o
  );
    logic [RW+1:0] a;
    logic [RW+1:0] b;
    a = {rem_i, bits_i};
    b = {2'b00, root_i, 2'b01};
    if (a >= b) begin
      rem_o  = RW'(a - b);
      root_o = HW'({root_i, 1'b1});
    end else begin
      rem_o  = RW'(a);
      root_o = HW'({root_i, 1'b0});
    end
  endfunction

  // ---------------------------------------------------------------------
  // Valid chain
  // ---------------------------------------------------------------------
  logic [LAT-1:0] vld_d, vld_q;
  logic [LAT-1:0] ld;

  // Shift arg_vld down the chain; bit s of vld_d is the incoming valid of stage s.
  always_comb begin
    vld_d = {vld_q[LAT-2:0], arg_vld};
  end

  // Valid register: the only state that must be cleared to flush in-flight samples.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign res_vld = vld_q[LAT-1];

  // Per-stage load enable: gated builds only move data alongside a valid sample.
  always_comb begin
`ifdef SQRT_SUM_PIPE_GATE_EN
    ld = vld_d;
`else
    ld = '1;
`endif
  end

  // ---------------------------------------------------------------------
  // Square-root pipelines, one per operand, HW stages each
  // ---------------------------------------------------------------------
  logic [RW-1:0] rem_d  [N_ARGS][HW];
  logic [RW-1:0] rem_q  [N_ARGS][HW];
  logic [HW-1:0] root_d [N_ARGS][HW];
  logic [HW-1:0] root_q [N_ARGS][HW];
  logic [W-1:0]  rad_d  [N_ARGS][HW];
  logic [W-1:0]  rad_q  [N_ARGS][HW];

  // Next state of every sqrt stage; stage k consumes the top two unconsumed radicand bits.
  always_comb begin
    rem_d  = rem_q;
    root_d = root_q;
    rad_d  = rad_q;
    for (int i = 0; i < N_ARGS; i++) begin
      if (ld[0]) begin
        sqrt_step('0, '0, arg[i*W + W-2 +: 2], rem_d[i][0], root_d[i][0]);
        rad_d[i][0] = arg[i*W +: W] << 2;
      end
      for (int k = 1; k < HW; k++) begin
        if (ld[k]) begin
          sqrt_step(rem_q[i][k-1], root_q[i][k-1], rad_q[i][k-1][W-1 -: 2],
                    rem_d[i][k], root_d[i][k]);
          rad_d[i][k] = rad_q[i][k-1] << 2;
        end
      end
    end
  end

  // Sqrt stage registers; the final root doubles as res when there is no adder tree.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    root_q <= root_d;
    rad_q  <= rad_d;
    if (rst && LOGN == 0) root_q[0][HW-1] <= '0;
  end

  // ---------------------------------------------------------------------
  // Registered adder tree, LOGN levels, every level at full OUT_W width
  // ---------------------------------------------------------------------
  if (LOGN > 0) begin : g_tree
    logic [OUT_W-1:0] lvl_in [LOGN][N_ARGS];
    logic [OUT_W-1:0] tree_d [LOGN][N_ARGS];
    logic [OUT_W-1:0] tree_q [LOGN][N_ARGS];

    // Level inputs: zero-extended roots feed level 0, each later level reads the one before.
    always_comb begin
      for (int j = 0; j < N_ARGS; j++) begin
        lvl_in[0][j] = OUT_W'(root_q[j][HW-1]);
      end
      for (int l = 1; l < LOGN; l++) begin
        for (int j = 0; j < N_ARGS; j++) begin
          lvl_in[l][j] = tree_q[l-1][j];
        end
      end
    end

    // Pairwise sums per level; an odd trailing element is carried through unchanged.
    always_comb begin
      tree_d = tree_q;
      for (int l = 0; l < LOGN; l++) begin
        if (ld[HW+l]) begin
          for (int j = 0; j < N_ARGS / 2; j++) begin
            if (2*j + 1 < lvl_cnt(l)) tree_d[l][j] = lvl_in[l][2*j] + lvl_in[l][2*j+1];
          end
          if (lvl_cnt(l) % 2 == 1) tree_d[l][lvl_cnt(l)/2] = lvl_in[l][lvl_cnt(l)-1];
        end
      end
    end

    // Tree registers; only the final sum (res) is cleared by reset.
    always_ff @(posedge clk) begin
      tree_q <= tree_d;
      if (rst) tree_q[LOGN-1][0] <= '0;
    end

    assign res = tree_q[LOGN-1][0];
  end else begin : g_no_tree
    assign res = root_q[0][HW-1];
  end

endmodule

// File: tb/tb_sqrt_sum_pipe.sv
// Directed bench for sqrt_sum_pipe: default (3 x 32b) and 4 x 16b instances.
// Expected results are queued with their due cycle when driven and checked on output.
// Both builds of SQRT_SUM_PIPE_GATE_EN are covered; hold checks apply to the gated build.
module tb_sqrt_sum_pipe;

  localparam int LAT_A = 18;
  localparam int LAT_B = 10;

  typedef struct {
    int              cyc;
    longint unsigned val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_vld = 1'b0;
  logic [95:0] a_arg = '0;
  logic        a_rvld;
  logic [17:0] a_res;
  logic        b_vld = 1'b0;
  logic [63:0] b_arg = '0;
  logic        b_rvld;
  logic [9:0]  b_res;

  int              cyc = 0;
  int              n_checks = 0;
  int              n_err = 0;
  bit              armed = 1'b0;
  longint unsigned a_last = 0;
  longint unsigned b_last = 0;
  exp_t            qa[$];
  exp_t            qb[$];

  sqrt_sum_pipe dut_a (
    .clk     (clk),
    .rst     (rst),
    .arg_vld (a_vld),
    .arg     (a_arg),
    .res_vld (a_rvld),
    .res     (a_res)
  );

  sqrt_sum_pipe #(.N_ARGS(4), .W(16)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .arg_vld (b_vld),
    .arg     (b_arg),
    .res_vld (b_rvld),
    .res     (b_res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: largest r with r*r <= x, found by trial multiplication.
  function automatic longint unsigned isqrt(input longint unsigned x, input int hw);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = hw - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  task automatic step_a(input logic v, input logic [31:0] x0, input logic [31:0] x1,
                        input logic [31:0] x2);
    exp_t e;
    a_vld = v;
    a_arg = {x2, x1, x0};
    b_vld = 1'b0;
    if (v) begin
      e.cyc = cyc + LAT_A;
      e.val = isqrt(x0, 16) + isqrt(x1, 16) + isqrt(x2, 16);
      qa.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input logic [15:0] x0, input logic [15:0] x1,
                        input logic [15:0] x2, input logic [15:0] x3);
    exp_t e;
    b_vld = v;
    b_arg = {x3, x2, x1, x0};
    a_vld = 1'b0;
    if (v) begin
      e.cyc = cyc + LAT_B;
      e.val = isqrt(x0, 8) + isqrt(x1, 8) + isqrt(x2, 8) + isqrt(x3, 8);
      qb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      a_vld = 1'b0;
      b_vld = 1'b0;
      a_arg = {$urandom, $urandom, $urandom};
      b_arg = {$urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst   = 1'b1;
    a_vld = 1'b0;
    b_vld = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    qa.delete();
    qb.delete();
    a_last = 0;
    b_last = 0;
    n_checks++;
    assert (a_rvld === 1'b0) else begin n_err++; $error("FAIL a_rst_vld observed=%b required=0", a_rvld); end
    n_checks++;
    assert (a_res === 18'd0) else begin n_err++; $error("FAIL a_rst_res observed=%0d required=0", a_res); end
    n_checks++;
    assert (b_rvld === 1'b0) else begin n_err++; $error("FAIL b_rst_vld observed=%b required=0", b_rvld); end
    n_checks++;
    assert (b_res === 10'd0) else begin n_err++; $error("FAIL b_rst_res observed=%0d required=0", b_res); end
    rst = 1'b0;
  endtask

  // Output checker for the default instance.
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (a_rvld) begin
        n_checks++;
        assert (qa.size() != 0) else begin n_err++; $error("FAIL a_extra_vld cyc=%0d observed res_vld=1 required 0", cyc); end
        if (qa.size() != 0) begin
          e = qa.pop_front();
          n_checks++;
          assert (e.cyc == cyc) else begin n_err++; $error("FAIL a_latency observed cyc=%0d required cyc=%0d", cyc, e.cyc); end
          n_checks++;
          assert (64'(a_res) === e.val) else begin n_err++; $error("FAIL a_res observed=%0d required=%0d", a_res, e.val); end
          a_last = e.val;
        end
      end else begin
        if (qa.size() != 0) begin
          n_checks++;
          assert (qa[0].cyc > cyc) else begin
            n_err++;
            $error("FAIL a_missing_vld cyc=%0d observed res_vld=0 required 1", cyc);
            void'(qa.pop_front());
          end
        end
`ifdef SQRT_SUM_PIPE_GATE_EN
        n_checks++;
        assert (64'(a_res) === a_last) else begin n_err++; $error("FAIL a_hold observed=%0d required=%0d", a_res, a_last); end
`endif
      end
    end
  end

  // Output checker for the 4 x 16b instance.
  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      if (b_rvld) begin
        n_checks++;
        assert (qb.size() != 0) else begin n_err++; $error("FAIL b_extra_vld cyc=%0d observed res_vld=1 required 0", cyc); end
        if (qb.size() != 0) begin
          e = qb.pop_front();
          n_checks++;
          assert (e.cyc == cyc) else begin n_err++; $error("FAIL b_latency observed cyc=%0d required cyc=%0d", cyc, e.cyc); end
          n_checks++;
          assert (64'(b_res) === e.val) else begin n_err++; $error("FAIL b_res observed=%0d required=%0d", b_res, e.val); end
          b_last = e.val;
        end
      end else begin
        if (qb.size() != 0) begin
          n_checks++;
          assert (qb[0].cyc > cyc) else begin
            n_err++;
            $error("FAIL b_missing_vld cyc=%0d observed res_vld=0 required 1", cyc);
            void'(qb.pop_front());
          end
        end
`ifdef SQRT_SUM_PIPE_GATE_EN
        n_checks++;
        assert (64'(b_res) === b_last) else begin n_err++; $error("FAIL b_hold observed=%0d required=%0d", b_res, b_last); end
`endif
      end
    end
  end

  initial begin
    #1;
    do_reset(2);
    armed = 1'b1;

    // Single sample: 4 + 5 + 6.
    step_a(1'b1, 32'd16, 32'd25, 32'd36);
    idle(20);

    // Floor rounding and extremes.
    step_a(1'b1, 32'd15, 32'd24, 32'd35);
    step_a(1'b1, 32'd0, 32'd0, 32'd0);
    step_a(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(3);

    // Bubble pattern 1,0,1,1,0,1.
    step_a(1'b1, $urandom, $urandom, $urandom);
    idle(1);
    step_a(1'b1, $urandom, $urandom, $urandom);
    step_a(1'b1, $urandom, $urandom, $urandom);
    idle(1);
    step_a(1'b1, $urandom, $urandom, $urandom);
    idle(20);

    // Back-to-back streaming.
    for (int n = 0; n < 100; n++) step_a(1'b1, $urandom, $urandom, $urandom);

    // Narrow instance: extremes, exact squares, random stream with a bubble.
    step_b(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step_b(1'b1, 16'd1, 16'd4, 16'd9, 16'd100);
    step_b(1'b1, 16'd0, 16'd0, 16'd0, 16'd0);
    for (int n = 0; n < 20; n++) begin
      step_b(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      if (n == 7) idle(2);
    end
    idle(25);

    // Reset mid-flight: five samples are flushed, the first post-reset sample survives.
    for (int n = 0; n < 5; n++) step_a(1'b1, $urandom, $urandom, $urandom);
    idle(5);
    do_reset(1);
    step_a(1'b1, 32'd100, 32'd400, 32'd900);
    idle(25);

    for (int n = 0; n < 60 && (qa.size() != 0 || qb.size() != 0); n++) idle(1);
    n_checks++;
    assert (qa.size() == 0 && qb.size() == 0) else begin
      n_err++;
      $error("FAIL drain observed pending=%0d/%0d required 0/0", qa.size(), qb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
